// File: rtl/jtag_led_top.sv
// JTAG LED demo top: IEEE 1149.1 TAP with an 8-bit IR, a 36-bit user DR selected by
// USER_OP, and a 34-bit LED register driving the RGB columns and one-hot row select.
module jtag_led_top #(
    parameter int                IR_LEN  = 8,
    parameter int                DR_LEN  = 36,
    parameter logic [IR_LEN-1:0] USER_OP = 8'h32
) (
    input  logic       TCK,
    input  logic       reset,
    input  logic       TMS,
    input  logic       TDI,
    output logic       TDO,
    output logic [9:0] red,
    output logic [9:0] green,
    output logic [9:0] blue,
    output logic [3:0] rgbRow
);

    localparam int LED_LEN = DR_LEN - 2;

    typedef enum logic [3:0] {
        S_TLR, S_RTI,
        S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PAU_DR, S_EX2_DR, S_UPD_DR,
        S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PAU_IR, S_EX2_IR, S_UPD_IR
    } tap_state_t;

    tap_state_t          state_r;
    tap_state_t          next_s;
    logic [IR_LEN-1:0]   ir_r;
    logic [IR_LEN-1:0]   ir_sh_r;
    logic [DR_LEN-1:0]   dr_sh_r;
    logic                byp_r;
    logic [LED_LEN-1:0]  led_r;
    logic                tdo_r;
    logic                user_s;
    logic                tlr_s;

    assign user_s = (ir_r == USER_OP);
    // Entering or holding Test-Logic-Reset restores IR and blanks the display.
    assign tlr_s  = (next_s == S_TLR);

    // TAP next-state per the 1149.1 TMS table
    always_comb begin
        next_s = S_TLR;
        case (state_r)
            S_TLR:    next_s = TMS ? S_TLR    : S_RTI;
            S_RTI:    next_s = TMS ? S_SEL_DR : S_RTI;
            S_SEL_DR: next_s = TMS ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: next_s = TMS ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  next_s = TMS ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: next_s = TMS ? S_UPD_DR : S_PAU_DR;
            S_PAU_DR: next_s = TMS ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: next_s = TMS ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: next_s = TMS ? S_SEL_DR : S_RTI;
            S_SEL_IR: next_s = TMS ? S_TLR    : S_CAP_IR;
            S_CAP_IR: next_s = TMS ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  next_s = TMS ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: next_s = TMS ? S_UPD_IR : S_PAU_IR;
            S_PAU_IR: next_s = TMS ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: next_s = TMS ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: next_s = TMS ? S_SEL_DR : S_RTI;
            default:  next_s = S_TLR;
        endcase
    end

    // TAP state register
    always_ff @(posedge TCK or posedge reset) begin
        if (reset) state_r <= S_TLR;
        else       state_r <= next_s;
    end

    // Instruction register and its shift stage
    always_ff @(posedge TCK or posedge reset) begin
        if (reset) begin
            ir_r    <= {IR_LEN{1'b1}};
            ir_sh_r <= {IR_LEN{1'b0}};
        end else begin
            if (tlr_s)                  ir_r <= {IR_LEN{1'b1}};
            else if (state_r == S_UPD_IR) ir_r <= ir_sh_r;
            else                        ir_r <= ir_r;
            case (state_r)
                S_CAP_IR: ir_sh_r <= {{(IR_LEN-1){1'b0}}, 1'b1};
                S_SH_IR:  ir_sh_r <= {TDI, ir_sh_r[IR_LEN-1:1]};
                default:  ir_sh_r <= ir_sh_r;
            endcase
        end
    end

    // User DR (captures the live display for readback) and the bypass bit
    always_ff @(posedge TCK or posedge reset) begin
        if (reset) begin
            dr_sh_r <= {DR_LEN{1'b0}};
            byp_r   <= 1'b0;
        end else begin
            case (state_r)
                S_CAP_DR: begin
                    dr_sh_r <= user_s ? {2'b00, led_r} : dr_sh_r;
                    byp_r   <= 1'b0;
                end
                S_SH_DR: begin
                    dr_sh_r <= user_s ? {TDI, dr_sh_r[DR_LEN-1:1]} : dr_sh_r;
                    byp_r   <= TDI;
                end
                default: begin
                    dr_sh_r <= dr_sh_r;
                    byp_r   <= byp_r;
                end
            endcase
        end
    end

    // LED register: loaded only by a user-DR update, cleared by TLR
    always_ff @(posedge TCK or posedge reset) begin
        if (reset)                             led_r <= {LED_LEN{1'b0}};
        else if (tlr_s)                        led_r <= {LED_LEN{1'b0}};
        else if (state_r == S_UPD_DR && user_s) led_r <= dr_sh_r[LED_LEN-1:0];
        else                                   led_r <= led_r;
    end

    // TDO launched on falling TCK so the host samples it stable on the next rising edge
    always_ff @(negedge TCK or posedge reset) begin
        if (reset) begin
            tdo_r <= 1'b0;
        end else begin
            case (state_r)
                S_SH_IR: tdo_r <= ir_sh_r[0];
                S_SH_DR: tdo_r <= user_s ? dr_sh_r[0] : byp_r;
                default: tdo_r <= 1'b0;
            endcase
        end
    end

    assign TDO    = tdo_r;
    assign rgbRow = led_r[3:0];
    assign red    = led_r[13:4];
    assign green  = led_r[23:14];
    assign blue   = led_r[33:24];

endmodule

// File: tb/tb_jtag_led_top.sv
// Directed bench for jtag_led_top: scan-level model of the expected display and TDO stream,
// checked every TCK cycle, plus literal pins on key results.
module tb_jtag_led_top;

    logic       TCK = 1'b0;
    logic       reset;
    logic       TMS;
    logic       TDI;
    logic       TDO;
    logic [9:0] red;
    logic [9:0] green;
    logic [9:0] blue;
    logic [3:0] rgbRow;

    logic [33:0] exp_led;
    logic        exp_tdo;
    int          n_checks = 0;
    int          n_errors = 0;

    localparam logic [35:0] PAT_A = {2'b00, 10'h000, 10'h000, 10'h07F, 4'b0001};
    localparam logic [35:0] PAT_B = {2'b11, 10'h2A5, 10'h15A, 10'h3C3, 4'b1000};
    localparam logic [35:0] PAT_C = {2'b01, 10'h3FF, 10'h001, 10'h200, 4'b0110};
    localparam logic [35:0] ONES  = {36{1'b1}};

    jtag_led_top dut (
        .TCK    (TCK),
        .reset  (reset),
        .TMS    (TMS),
        .TDI    (TDI),
        .TDO    (TDO),
        .red    (red),
        .green  (green),
        .blue   (blue),
        .rgbRow (rgbRow)
    );

    always #5 TCK = ~TCK;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, between the rising edge and the following falling edge
    always @(posedge TCK) begin
        #2;
        check("rgbRow", 36'(rgbRow), 36'(exp_led[3:0]));
        check("red",    36'(red),    36'(exp_led[13:4]));
        check("green",  36'(green),  36'(exp_led[23:14]));
        check("blue",   36'(blue),   36'(exp_led[33:24]));
        check("tdo",    36'(TDO),    36'(exp_tdo));
    end

    // One TCK cycle; etdo is the TDO value expected just after this rising edge.
    task automatic tick(input logic tms, input logic tdi, input logic etdo);
        @(negedge TCK);
        TMS     = tms;
        TDI     = tdi;
        exp_tdo = etdo;
        @(posedge TCK);
        #3;
    endtask

    // From Run-Test/Idle: full IR scan back to Run-Test/Idle
    task automatic ir_scan(input logic [7:0] op);
        logic [7:0] cap;
        cap = 8'h01;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) tick(i == 7, op[i], cap[i]);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    // From Run-Test/Idle: full 36-bit DR scan; user selects the readback/update model
    task automatic dr_scan(input logic [35:0] data, input logic user);
        logic [35:0] out;
        out = user ? {2'b00, exp_led} : {data[34:0], 1'b0};
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 36; i++) tick(i == 35, data[i], out[i]);
        tick(1'b1, 1'b0, 1'b0);
        if (user) exp_led = data[33:0];
        tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [35:0] cap;
        logic [35:0] part;
        reset   = 1'b1;
        TMS     = 1'b1;
        TDI     = 1'b0;
        exp_led = 34'h0;
        exp_tdo = 1'b0;
        repeat (3) @(posedge TCK);
        @(negedge TCK);
        #1 reset = 1'b0;
        check("rst_red_lit", 36'(red), 36'h0);
        check("rst_row_lit", 36'(rgbRow), 36'h0);
        tick(1'b0, 1'b0, 1'b0);

        // Load the user opcode (IR capture reads back 0x01), then a display word
        ir_scan(8'h32);
        dr_scan(PAT_A, 1'b1);
        check("a_model_lit", 36'(exp_led), 36'h0000007F1);
        check("a_red_lit",   36'(red),     36'h07F);
        check("a_row_lit",   36'(rgbRow),  36'h1);

        // All-zero scan reads back the previous word and blanks the display
        dr_scan(36'h0, 1'b1);
        check("z_red_lit", 36'(red), 36'h0);
        dr_scan(PAT_B, 1'b1);
        check("b_blue_lit", 36'(blue), 36'h2A5);

        // Bypass: TDO is TDI delayed one bit, display untouched
        ir_scan(8'hFF);
        dr_scan(ONES, 1'b0);
        check("byp_green_lit", 36'(green), 36'h15A);

        // Five TMS=1 clocks out of Shift-DR: passes Update-DR, then TLR clears everything
        ir_scan(8'h32);
        cap = {2'b00, exp_led};
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(i == 3, 1'b0, cap[i]);
        tick(1'b1, 1'b0, 1'b0);
        part    = cap >> 4;
        exp_led = part[33:0];
        tick(1'b1, 1'b0, 1'b0);
        check("esc_red_lit", 36'(red),    36'h2BC);
        check("esc_row_lit", 36'(rgbRow), 36'h3);
        tick(1'b1, 1'b0, 1'b0);
        exp_led = 34'h0;
        tick(1'b1, 1'b0, 1'b0);
        check("tlr_blue_lit", 36'(blue), 36'h0);
        tick(1'b0, 1'b0, 1'b0);
        dr_scan(ONES, 1'b0);

        // Reset in the middle of a user-DR shift
        ir_scan(8'h32);
        dr_scan(PAT_C, 1'b1);
        check("c_row_lit", 36'(rgbRow), 36'h6);
        cap = {2'b00, exp_led};
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, cap[i]);
        exp_led = 34'h0;
        exp_tdo = 1'b0;
        reset   = 1'b1;
        #1;
        check("mid_rst_blue", 36'(blue),  36'h0);
        check("mid_rst_red",  36'(red),   36'h0);
        check("mid_rst_tdo",  36'(TDO),   36'h0);
        repeat (2) @(posedge TCK);
        @(negedge TCK);
        TMS = 1'b1;
        #1 reset = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        dr_scan(ONES, 1'b0);
        check("end_green_lit", 36'(green), 36'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
